// File: rtl/binary_to_bcd_sequencer_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package binary_to_bcd_sequencer_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Ceiling log2, used to size the step counter.
  function automatic int unsigned bcd_clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_to_bcd_sequencer_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the combined {bcd, bin} vector left by one bit.
module bcd_dabble_step #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic [WIDTH-1:0]    i_bin,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic [WIDTH-1:0]    o_bin
);

  logic [4*DIGITS-1:0] w_adj;

  // Digit adjust followed by the one-bit shift of the joint register.
  always_comb begin
    w_adj = i_bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (i_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
      end
    end
    {o_bcd, o_bin} = {w_adj, i_bin} << 1;
  end

endmodule

// File: rtl/binary_to_bcd_sequencer.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock,
// with valid/ready handshakes on both sides.
module binary_to_bcd_sequencer
  import binary_to_bcd_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                busy
);

  localparam int unsigned CW_RAW = bcd_clog2(WIDTH + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] r_out_bcd;
  logic                r_out_valid;
  logic                r_busy;

  logic [4*DIGITS-1:0] w_bcd_next;
  logic [WIDTH-1:0]    w_bin_next;

  bcd_dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .i_bcd (r_bcd),
    .i_bin (r_bin),
    .o_bcd (w_bcd_next),
    .o_bin (w_bin_next)
  );

  // FSM, step counter, working registers and registered handshake outputs.
  // The finished result is copied into its own register on the last step so
  // the output holds the previous result while a new conversion is shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin   <= in_data;
            r_bcd   <= '0;
            r_count <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd   <= w_bcd_next;
          r_bin   <= w_bin_next;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_out_bcd   <= w_bcd_next;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_bin   <= in_data;
              r_bcd   <= '0;
              r_count <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Input side may accept while the current result is being taken.
  always_comb begin
    in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  end

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign busy      = r_busy;

endmodule

// File: tb/tb_binary_to_bcd_sequencer.sv
// Self-checking bench for binary_to_bcd_sequencer (WIDTH=8, DIGITS=3).
module tb_binary_to_bcd_sequencer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                busy;

  int checks;
  int errors;

  binary_to_bcd_sequencer #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [4*DIGITS-1:0] bcd_ref(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one value, wait for the result, report it and its latency, then consume it.
  task automatic run_one(input logic [WIDTH-1:0] v, output logic [4*DIGITS-1:0] res, output int lat);
    int g;
    @(negedge clk);
    in_valid = 1'b1; in_data = v; out_ready = 1'b0;
    #1;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0; in_data = WIDTH'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = out_bcd;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [4*DIGITS-1:0] res;
    logic [4*DIGITS-1:0] exp_q[$];
    logic [4*DIGITS-1:0] e;
    int lat;
    int n;
    int next_v;
    int received;
    int cyc;
    bit seen;
    bit in_fire, out_fire;

    checks = 0; errors = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'h000);

    // Zero: latency, result, and return to IDLE.
    run_one(8'd0, res, lat);
    chk("zero_latency", 32'(lat), 32'(WIDTH));
    chk("zero_bcd", 32'(res), 32'h000);
    chk("zero_idle_in_ready", 32'(in_ready), 32'd1);
    chk("zero_idle_out_valid", 32'(out_valid), 32'd0);

    run_one(8'd255, res, lat);
    chk("v255", 32'(res), 32'h255);
    chk("v255_latency", 32'(lat), 32'(WIDTH));
    run_one(8'd99, res, lat);
    chk("v99", 32'(res), 32'h099);
    run_one(8'd100, res, lat);
    chk("v100", 32'(res), 32'h100);

    // Backpressure on 173.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd173; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_busy", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_latency", 32'(n), 32'(WIDTH));
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_bcd", 32'(out_bcd), 32'h173);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Back-to-back: 200 then 47 with out_ready held high.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b1;
    @(negedge clk);
    in_data = 8'd47;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("b2b_first_bcd", 32'(out_bcd), 32'h200);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("b2b_valid_drop", 32'(out_valid), 32'd0);
    chk("b2b_busy_rise", 32'(busy), 32'd1);
    in_valid = 1'b0; in_data = 8'd3;
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("b2b_spacing", 32'(n), 32'(WIDTH + 1));
    chk("b2b_second_bcd", 32'(out_bcd), 32'h047);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after 4 shift steps of 231 aborts the conversion.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd231;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_bcd", 32'(out_bcd), 32'h000);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // Sweep 0..255 with random producer and consumer stalls.
    next_v = 0; received = 0; cyc = 0;
    while (received < 256 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (next_v < 256) && ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'(next_v);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          chk("sweep_unexpected", 32'(out_bcd), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sweep_result", 32'(out_bcd), 32'(e));
        end
        received++;
      end
      if (in_fire) begin
        exp_q.push_back(bcd_ref(32'(next_v)));
        next_v++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sweep_received", 32'(received), 32'd256);
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
